// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one period->frequency divider between N_CH channels,
// with operand screening, divider timeout recovery and a post-reset drain period.
module div_arbiter #(
  parameter int N_CH         = 2,
  parameter int MIN_PERIOD   = 1956,
  parameter int TIMEOUT      = 128,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req,
  input  logic [14*N_CH-1:0]   period,
  output logic [N_CH-1:0]      rsp_valid,
  output logic [8:0]           rsp_freq,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [13:0]          div_divider,
  output logic                 div_enable,
  input  logic [8:0]           div_freq,
  input  logic                 div_done
);

  localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_MAX = (TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_reg;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic [13:0]      sel_period;
  logic [N_CH-1:0]  grant_onehot;
  logic [N_CH-1:0]  held_onehot;
  logic [PTR_W-1:0] rr_next;

  // Two passes give a wrapping search: first from rr_ptr upward, then from bit 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (!grant_found && req[j] && (PTR_W'(j) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(j);
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (!grant_found && req[j]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(j);
      end
    end
  end

  always_comb begin
    sel_period = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_idx == PTR_W'(k)) sel_period = period[14*k +: 14];
    end
  end

  assign grant_onehot = N_CH'(1) << grant_idx;
  assign held_onehot  = N_CH'(1) << grant_reg;
  assign rr_next      = (grant_reg == PTR_W'(N_CH - 1)) ? '0 : grant_reg + 1'b1;
  assign busy         = (state != S_IDLE);

  // The divider has no reset of its own, so any result it produces during FLUSH or
  // outside WAIT is stale and deliberately ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FLUSH;
      cnt         <= '0;
      rr_ptr      <= '0;
      grant_reg   <= '0;
      rsp_valid   <= '0;
      rsp_freq    <= '0;
      rsp_err     <= 1'b0;
      div_divider <= '0;
      div_enable  <= 1'b0;
    end else begin
      case (state)
        S_FLUSH: begin
          if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (grant_found) begin
            grant_reg <= grant_idx;
            if (sel_period < 14'(MIN_PERIOD)) begin
              rsp_valid <= grant_onehot;
              rsp_err   <= 1'b1;
              rsp_freq  <= (sel_period == 14'd0) ? 9'd0 : 9'h1FF;
              state     <= S_RESP;
            end else begin
              div_divider <= sel_period;
              state       <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          div_enable <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
          div_enable <= 1'b0;
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            rsp_valid <= held_onehot;
            rsp_freq  <= div_freq;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid <= held_onehot;
            rsp_freq  <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid <= '0;
          rsp_freq  <= '0;
          rsp_err   <= 1'b0;
          rr_ptr    <= rr_next;
          state     <= S_IDLE;
        end
        default: state <= S_FLUSH;
      endcase
    end
  end

endmodule
